// File: rtl/pc_stack_unit.sv
// Program counter register with a next-PC selector and a circular return-address
// stack for call/return. Owns the PC register and drives the fetch address.
module pc_stack_unit #(
    parameter int WIDTH       = 16,
    parameter int JIMM_W      = 12,
    parameter int INC         = 2,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0
) (
    input  logic                           CLK,
    input  logic                           Reset_n,
    input  logic                           PCWrite,
    input  logic [2:0]                     s,
    input  logic [WIDTH-1:0]               ALUPC,
    input  logic [JIMM_W-1:0]              JumpImm,
    input  logic                           ClearFlags,
    output logic [WIDTH-1:0]               PC,
    output logic [WIDTH-1:0]               PCNext,
    output logic [$clog2(STACK_DEPTH):0]   Depth,
    output logic                           Empty,
    output logic                           Full,
    output logic                           Overflow,
    output logic                           Underflow
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

    localparam logic [2:0] S_ALU  = 3'd0;
    localparam logic [2:0] S_JMP  = 3'd1;
    localparam logic [2:0] S_CALL = 3'd3;
    localparam logic [2:0] S_RET  = 3'd4;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc, jmp_tgt, tos;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [PW-1:0]    top_q, top_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             empty, full, push;

    assign pc_inc  = pc_q + WIDTH'(INC);
    assign jmp_tgt = {pc_inc[WIDTH-1:JIMM_W+1], JumpImm, 1'b0};
    assign tos     = stack_q[top_q];
    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DEPTH_MAX);
    assign push    = PCWrite && (s == S_CALL);

    always_comb begin
        PCNext = pc_inc;
        case (s)
            S_ALU:         PCNext = ALUPC;
            S_JMP, S_CALL: PCNext = jmp_tgt;
            S_RET:         PCNext = empty ? pc_inc : tos;
            default:       PCNext = pc_inc;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        top_d   = top_q;
        depth_d = depth_q;
        ovf_d   = ClearFlags ? 1'b0 : ovf_q;
        unf_d   = ClearFlags ? 1'b0 : unf_q;
        if (PCWrite) begin
            pc_d = PCNext;
            if (s == S_CALL) begin
                // A full stack wraps onto its oldest entry; depth saturates.
                top_d = top_q + PW'(1);
                if (full) ovf_d = 1'b1;
                else      depth_d = depth_q + DW'(1);
            end else if (s == S_RET) begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    top_d   = top_q - PW'(1);
                    depth_d = depth_q - DW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q    <= WIDTH'(RESET_PC);
            top_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries are only meaningful below depth_q, so the array needs no reset.
    always_ff @(posedge CLK) begin
        if (push) stack_q[top_d] <= pc_inc;
    end

    assign PC        = pc_q;
    assign Depth     = depth_q;
    assign Empty     = empty;
    assign Full      = full;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with hand-computed expectations (default parameters).
module tb_pc_stack_unit;
    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        PCWrite = 1'b1;
    logic [2:0]  s = 3'd2;
    logic [15:0] ALUPC = '0;
    logic [11:0] JumpImm = '0;
    logic        ClearFlags = 1'b0;
    logic [15:0] PC, PCNext;
    logic [3:0]  Depth;
    logic        Empty, Full, Overflow, Underflow;

    int checks = 0;
    int errors = 0;

    pc_stack_unit dut (
        .CLK(CLK), .Reset_n(Reset_n), .PCWrite(PCWrite), .s(s), .ALUPC(ALUPC),
        .JumpImm(JumpImm), .ClearFlags(ClearFlags), .PC(PC), .PCNext(PCNext),
        .Depth(Depth), .Empty(Empty), .Full(Full), .Overflow(Overflow),
        .Underflow(Underflow)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_pc(input logic [15:0] v);
        PCWrite = 1'b1; ClearFlags = 1'b0; s = 3'd0; ALUPC = v;
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (PC !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", PC); end
        checks++;
        if ({Depth, Empty, Full, Overflow, Underflow} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_status: got d=%0d e=%b f=%b o=%b u=%b want 0 1 0 0 0",
                               Depth, Empty, Full, Overflow, Underflow);
        end
        checks++;
        if (PCNext !== 16'h0002) begin errors++; $display("FAIL reset_pcnext: got %h want 0002", PCNext); end
        #10 Reset_n = 1'b1;
    endtask

    task automatic test_increment();
        logic [15:0] exp_pc [4] = '{16'h2, 16'h4, 16'h6, 16'h8};
        s = 3'd2; PCWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (PC !== exp_pc[i]) begin errors++; $display("FAIL inc_%0d: got %h want %h", i, PC, exp_pc[i]); end
        end
    endtask

    task automatic test_branch_jump();
        load_pc(16'h0040);
        s = 3'd0; ALUPC = 16'd25;
        tick();
        checks++;
        if (PC !== 16'd25) begin errors++; $display("FAIL alupc: got %h want 0019", PC); end
        s = 3'd1; JumpImm = 12'd127;
        #1;
        checks++;
        if (PCNext !== 16'h00FE) begin errors++; $display("FAIL jump_pcnext: got %h want 00fe", PCNext); end
        tick();
        checks++;
        if (PC !== 16'h00FE) begin errors++; $display("FAIL jump_pc: got %h want 00fe", PC); end
    endtask

    task automatic test_call_return();
        load_pc(16'h0100);
        s = 3'd3; JumpImm = 12'h200;
        tick();
        checks++;
        if (PC !== 16'h0400 || Depth !== 4'd1 || Empty !== 1'b0) begin
            errors++; $display("FAIL call: got pc=%h d=%0d e=%b want 0400 1 0", PC, Depth, Empty);
        end
        s = 3'd5;
        tick();
        checks++;
        if (PC !== 16'h0402 || Depth !== 4'd1 || Overflow !== 1'b0 || Underflow !== 1'b0) begin
            errors++; $display("FAIL reserved_sel: got pc=%h d=%0d o=%b u=%b want 0402 1 0 0",
                               PC, Depth, Overflow, Underflow);
        end
        s = 3'd4;
        #1;
        checks++;
        if (PCNext !== 16'h0102) begin errors++; $display("FAIL ret_pcnext: got %h want 0102", PCNext); end
        tick();
        checks++;
        if (PC !== 16'h0102 || Depth !== 4'd0 || Empty !== 1'b1) begin
            errors++; $display("FAIL ret: got pc=%h d=%0d e=%b want 0102 0 1", PC, Depth, Empty);
        end
    endtask

    task automatic test_back_to_back();
        // From 0x0102: call pushes 0x0104, next-cycle return must pop it.
        s = 3'd3; JumpImm = 12'h010;
        tick();
        checks++;
        if (PC !== 16'h0020) begin errors++; $display("FAIL b2b_call: got %h want 0020", PC); end
        s = 3'd4;
        tick();
        checks++;
        if (PC !== 16'h0104 || Depth !== 4'd0) begin
            errors++; $display("FAIL b2b_ret: got pc=%h d=%0d want 0104 0", PC, Depth);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] ret [10];
        load_pc(16'h0300);
        // Call k jumps to k*0x20; its return address is PC-before-call + 2.
        for (int k = 1; k <= 9; k++) begin
            ret[k] = (k == 1) ? 16'h0302 : 16'((k - 1) * 32 + 2);
            s = 3'd3; JumpImm = 12'(k * 16);
            tick();
        end
        checks++;
        if (PC !== 16'h0120 || Depth !== 4'd8 || Full !== 1'b1 || Overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_state: got pc=%h d=%0d f=%b o=%b want 0120 8 1 1",
                               PC, Depth, Full, Overflow);
        end
        for (int k = 9; k >= 2; k--) begin
            s = 3'd4;
            tick();
            checks++;
            if (PC !== ret[k]) begin errors++; $display("FAIL pop_call%0d: got %h want %h", k, PC, ret[k]); end
        end
        checks++;
        if (Depth !== 4'd0 || Empty !== 1'b1 || Underflow !== 1'b0) begin
            errors++; $display("FAIL drained: got d=%0d e=%b u=%b want 0 1 0", Depth, Empty, Underflow);
        end
        tick();
        checks++;
        if (PC !== 16'h0024 || Underflow !== 1'b1 || Depth !== 4'd0) begin
            errors++; $display("FAIL underflow: got pc=%h u=%b d=%0d want 0024 1 0", PC, Underflow, Depth);
        end
        ClearFlags = 1'b1;
        tick();
        checks++;
        if (Underflow !== 1'b1 || Overflow !== 1'b0 || PC !== 16'h0026) begin
            errors++; $display("FAIL clear_vs_err: got u=%b o=%b pc=%h want 1 0 0026", Underflow, Overflow, PC);
        end
        s = 3'd2;
        tick();
        ClearFlags = 1'b0;
        checks++;
        if (Underflow !== 1'b0 || Overflow !== 1'b0) begin
            errors++; $display("FAIL clear: got u=%b o=%b want 0 0", Underflow, Overflow);
        end
    endtask

    task automatic test_stall();
        s = 3'd4;
        tick();
        load_pc(16'h0010);
        PCWrite = 1'b0; s = 3'd3; JumpImm = 12'h005;
        #1;
        checks++;
        if (PCNext !== 16'h000A) begin errors++; $display("FAIL stall_pcnext: got %h want 000a", PCNext); end
        for (int i = 0; i < 3; i++) begin
            ClearFlags = (i == 2);
            tick();
            checks++;
            if (PC !== 16'h0010 || Depth !== 4'd0) begin
                errors++; $display("FAIL stall_%0d: got pc=%h d=%0d want 0010 0", i, PC, Depth);
            end
            checks++;
            if (Underflow !== (i != 2)) begin
                errors++; $display("FAIL stall_flag_%0d: got %b want %b", i, Underflow, (i != 2));
            end
        end
        ClearFlags = 1'b0; PCWrite = 1'b1;
    endtask

    task automatic test_wrap();
        load_pc(16'hFFFE);
        s = 3'd2;
        tick();
        checks++;
        if (PC !== 16'h0000) begin errors++; $display("FAIL wrap: got %h want 0000", PC); end
    endtask

    task automatic test_async_reset();
        s = 3'd3; JumpImm = 12'h040;
        tick();
        JumpImm = 12'h050;
        tick();
        checks++;
        if (Depth !== 4'd2 || PC !== 16'h00A0) begin
            errors++; $display("FAIL pre_reset: got d=%0d pc=%h want 2 00a0", Depth, PC);
        end
        @(negedge CLK);
        Reset_n = 1'b0;
        #1;
        checks++;
        if (PC !== 16'h0000 || Depth !== 4'd0 || Empty !== 1'b1) begin
            errors++; $display("FAIL async_reset: got pc=%h d=%0d e=%b want 0000 0 1", PC, Depth, Empty);
        end
        #1 Reset_n = 1'b1;
        s = 3'd2;
        tick();
        checks++;
        if (PC !== 16'h0002) begin errors++; $display("FAIL post_reset: got %h want 0002", PC); end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_branch_jump();
        test_call_return();
        test_back_to_back();
        test_overflow();
        test_stall();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
